// File: rtl/regstore_32x64.sv
// Storage core of the 32 x 64-bit integer register file: one write port,
// per-bit mux2_1 + DFF cells, full packed image out, X31 hardwired to zero.

module regstore_mux2_1 (
  input  logic sel,
  input  logic a,
  input  logic b,
  output logic y
);
  // sel=0 -> a (hold path), sel=1 -> b (new data)
  assign y = sel ? b : a;
endmodule

module regstore_dff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk) begin
    if (reset) q <= 1'b0;
    else       q <= d;
  end
endmodule

module regstore_dec2to4 (
  input  logic [1:0] sel,
  output logic [3:0] dec
);
  assign dec[0] = ~sel[1] & ~sel[0];
  assign dec[1] = ~sel[1] &  sel[0];
  assign dec[2] =  sel[1] & ~sel[0];
  assign dec[3] =  sel[1] &  sel[0];
endmodule

module regstore_dec3to8 (
  input  logic [2:0] sel,
  output logic [7:0] dec
);
  assign dec[0] = ~sel[2] & ~sel[1] & ~sel[0];
  assign dec[1] = ~sel[2] & ~sel[1] &  sel[0];
  assign dec[2] = ~sel[2] &  sel[1] & ~sel[0];
  assign dec[3] = ~sel[2] &  sel[1] &  sel[0];
  assign dec[4] =  sel[2] & ~sel[1] & ~sel[0];
  assign dec[5] =  sel[2] & ~sel[1] &  sel[0];
  assign dec[6] =  sel[2] &  sel[1] & ~sel[0];
  assign dec[7] =  sel[2] &  sel[1] &  sel[0];
endmodule

module regstore_row #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] d;

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    regstore_mux2_1 u_mux (
      .sel (en),
      .a   (q[b]),
      .b   (wdata[b]),
      .y   (d[b])
    );
    regstore_dff u_dff (
      .clk   (clk),
      .reset (reset),
      .d     (d[b]),
      .q     (q[b])
    );
  end
endmodule

module regstore_32x64 #(
  parameter int WIDTH    = 64,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 31
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        RegWrite,
  input  logic [4:0]                  WriteRegister,
  input  logic [WIDTH-1:0]            WriteData,
  output logic [NREGS-1:0][WIDTH-1:0] RegArray
);
  logic [3:0] dec_hi;
  logic [7:0] dec_lo;

  // Upper two address bits pick a bank of eight, lower three pick within it.
  regstore_dec2to4 u_dec_hi (
    .sel (WriteRegister[4:3]),
    .dec (dec_hi)
  );
  regstore_dec3to8 u_dec_lo (
    .sel (WriteRegister[2:0]),
    .dec (dec_lo)
  );

  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    if (i == ZERO_REG) begin : g_zero
      assign RegArray[i] = '0;
    end else begin : g_store
      logic en;
      // RegWrite gates the decode so an unknown index with RegWrite=0 stays inert.
      assign en = RegWrite & dec_hi[i / 8] & dec_lo[i % 8];
      regstore_row #(.WIDTH(WIDTH)) u_row (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .wdata (WriteData),
        .q     (RegArray[i])
      );
    end
  end
endmodule

// File: tb/tb_regstore_32x64.sv
// Directed self-checking bench for regstore_32x64: reset, writes, XZR,
// write-disable sweep, back-to-back writes, full fill then reset.
`timescale 1ns/1ps

module tb_regstore_32x64;
  localparam int WIDTH = 64;
  localparam int NREGS = 32;

  logic                        clk;
  logic                        reset;
  logic                        RegWrite;
  logic [4:0]                  WriteRegister;
  logic [WIDTH-1:0]            WriteData;
  logic [NREGS-1:0][WIDTH-1:0] RegArray;

  logic [WIDTH-1:0] model [NREGS];
  logic [WIDTH-1:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;

  regstore_32x64 dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .RegArray      (RegArray)
  );

  // clock/reset block: 10 ns period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < NREGS; i++)
      check($sformatf("%s[%0d]", tag, i), RegArray[i], model[i]);
  endtask

  // Drive at the negedge, let one rising edge pass, settle 1 ns.
  task automatic drive_cycle(input logic rst, input logic we, input logic [4:0] idx,
                             input logic [WIDTH-1:0] data);
    @(negedge clk);
    reset         = rst;
    RegWrite      = we;
    WriteRegister = idx;
    WriteData     = data;
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < NREGS; i++) model[i] = '0;
    end else if (we && idx != 5'd31) begin
      model[idx] = data;
    end
  endtask

  task automatic do_write(input logic [4:0] idx, input logic [WIDTH-1:0] data);
    drive_cycle(1'b0, 1'b1, idx, data);
  endtask

  initial begin
    reset         = 1'b1;
    RegWrite      = 1'b1;
    WriteRegister = 5'd5;
    WriteData     = 64'hFFFF;
    for (int i = 0; i < NREGS; i++) model[i] = '0;

    // 1: reset held for two edges overrides a pending write
    drive_cycle(1'b1, 1'b1, 5'd5, 64'hFFFF);
    drive_cycle(1'b1, 1'b1, 5'd5, 64'hFFFF);
    check_all("reset");

    // 2: two ordinary writes
    do_write(5'd3, 64'hDEAD_BEEF_0123_4567);
    do_write(5'd4, 64'h1);
    check("x3", RegArray[3], 64'hDEAD_BEEF_0123_4567);
    check("x4", RegArray[4], 64'h1);
    check_all("after_x3_x4");

    // 3: write to XZR is ignored
    do_write(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    check("xzr", RegArray[31], 64'h0);
    check_all("after_xzr");

    // 4: RegWrite=0 sweep leaves everything alone
    for (int i = 0; i < NREGS; i++)
      drive_cycle(1'b0, 1'b0, 5'(i), {$urandom(), $urandom()});
    @(negedge clk);
    WriteRegister = 5'bx0x1x;
    WriteData     = {$urandom(), $urandom()};
    @(posedge clk);
    #1;
    check_all("we_off");

    // 5: back-to-back writes to X7; old value visible until the second edge
    do_write(5'd7, 64'hA);
    @(negedge clk);
    RegWrite      = 1'b1;
    WriteRegister = 5'd7;
    WriteData     = 64'hB;
    #1;
    check("x7_before_edge", RegArray[7], 64'hA);
    @(posedge clk);
    #1;
    model[7] = 64'hB;
    check("x7_last_wins", RegArray[7], 64'hB);

    // consecutive writes to different indices both land
    do_write(5'd10, 64'h1234_5678_9ABC_DEF0);
    do_write(5'd11, 64'h0FED_CBA9_8765_4321);
    check_all("consec");

    // 6: fill X0..X30, read back through the expected queue, then reset
    for (int i = 0; i < NREGS - 1; i++) begin
      do_write(5'(i), 64'(i) * 64'h0101_0101_0101_0101);
      exp_q.push_back(64'(i) * 64'h0101_0101_0101_0101);
    end
    exp_q.push_back(64'h0);
    for (int i = 0; i < NREGS; i++) begin
      logic [WIDTH-1:0] e;
      e = exp_q.pop_front();
      check($sformatf("fill[%0d]", i), RegArray[i], e);
    end
    drive_cycle(1'b1, 1'b0, 5'd0, '0);
    check_all("fill_reset");

    // first edge after reset accepts a write
    do_write(5'd1, 64'hCAFE);
    check("post_reset_write", RegArray[1], 64'hCAFE);
    check_all("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
